// File: rtl/xadc_pkg.sv
// Shared widths, defaults and state encoding for the serial ADC reader.
// Pure declarations with no logic and no latency of its own.
package xadc_pkg;
    localparam int ADC_DATA_W         = 8;
    localparam int XADC_CLK_DIV       = 4;
    localparam int XADC_FRAME_BITS    = 16;
    localparam int XADC_LEAD_BITS     = 3;
    localparam int XADC_QUIET_CYCLES  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DONE,
        GAP
    } xadc_state_t;
endpackage

// File: rtl/xadc_sclk_gen.sv
// Half-period counter producing the registered ADC serial clock plus rise/fall enables.
// Edges are CLK_DIV cycles apart while running; with no run request it idles high.
module xadc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_last,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_tc;

    assign w_tc   = i_run && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise = w_tc && !r_sclk;
    assign o_fall = w_tc && r_sclk;
    assign o_sclk = r_sclk;

    // On the final high half the terminal count still pulses o_fall, but sclk is parked high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
        end else if (w_tc) begin
            r_cnt  <= '0;
            r_sclk <= !(r_sclk && !i_last);
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/xadc_reader.sv
// Reads one MSB-first frame from an SPI-style ADC and strobes the sample out; valid 1+CLK_DIV*(2*FRAME_BITS+1) cycles after start.
// No backpressure: adc_valid is a one-cycle strobe, adc_data holds until the next frame.
module xadc_reader
    import xadc_pkg::*;
#(
    parameter int CLK_DIV      = XADC_CLK_DIV,
    parameter int FRAME_BITS   = XADC_FRAME_BITS,
    parameter int LEAD_BITS    = XADC_LEAD_BITS,
    parameter int DATA_W       = ADC_DATA_W,
    parameter int QUIET_CYCLES = XADC_QUIET_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              adc_sdata,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_valid,
    output logic              busy
);
    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam int GC_W = (QUIET_CYCLES > 2) ? $clog2(QUIET_CYCLES) : 1;

    if (LEAD_BITS + DATA_W > FRAME_BITS) begin : g_bad_frame
        $error("xadc_reader: LEAD_BITS + DATA_W exceeds FRAME_BITS");
    end
    if (CLK_DIV < 2 || QUIET_CYCLES < 2 || DATA_W < 2) begin : g_bad_timing
        $error("xadc_reader: CLK_DIV, QUIET_CYCLES and DATA_W must be at least 2");
    end

    xadc_state_t       r_state;
    xadc_state_t       w_next_state;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [GC_W-1:0]   r_gap_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_cs_n;
    logic              r_busy;
    logic              w_run;
    logic              w_last;
    logic              w_rise;
    logic              w_fall;
    logic              w_sclk;
    logic              w_in_window;

    xadc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (w_run),
        .i_last (w_last),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_in_window = (r_bit_cnt >= BC_W'(LEAD_BITS)) &&
                         (r_bit_cnt <  BC_W'(LEAD_BITS + DATA_W));

    // DONE is the first quiet cycle, so GAP runs QUIET_CYCLES-1 cycles before IDLE may restart.
    always_comb begin
        w_next_state = r_state;
        w_run        = (r_state == CS_SETUP) || (r_state == SHIFT);
        w_last       = (r_state == SHIFT) && (r_bit_cnt == BC_W'(FRAME_BITS));
        case (r_state)
            IDLE:     if (enable) w_next_state = CS_SETUP;
            CS_SETUP: if (w_fall) w_next_state = SHIFT;
            SHIFT:    if (w_fall && w_last) w_next_state = DONE;
            DONE:     w_next_state = GAP;
            GAP:      if (r_gap_cnt == GC_W'(QUIET_CYCLES - 2)) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cs_n  <= !((w_next_state == CS_SETUP) || (w_next_state == SHIFT));
            r_busy  <= (w_next_state != IDLE);
            r_valid <= (w_next_state == DONE);
            if (w_next_state == DONE) begin
                r_data <= r_shift;
            end
            // Sample on the edge that drives sclk high; the ADC has had a full low half to settle.
            if (r_state == SHIFT) begin
                if (w_rise) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_in_window) begin
                        r_shift <= {r_shift[DATA_W-2:0], adc_sdata};
                    end
                end
            end else begin
                r_bit_cnt <= '0;
            end
            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign adc_sclk  = w_sclk;
    assign adc_cs_n  = r_cs_n;
    assign adc_data  = r_data;
    assign adc_valid = r_valid;
    assign busy      = r_busy;
endmodule
